// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared types and constants for the packet round-robin arbiter
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } arb_state_t;

  localparam int CNT_W = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_rr_arbiter_if.sv
// rtl/pkt_rr_arbiter_if.sv - flattened ingress streams, merged egress stream and grant debug
interface pkt_rr_arbiter_if
  import pkt_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS          = 4
);
  localparam int IW = idx_w(C_NUM_PORTS);

  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata;
  logic [C_NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep;
  logic [C_NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser;
  logic [C_NUM_PORTS-1:0]                       s_axis_tvalid;
  logic [C_NUM_PORTS-1:0]                       s_axis_tlast;
  logic [C_NUM_PORTS-1:0]                       s_axis_tready;
  logic [C_S_AXIS_DATA_WIDTH-1:0]               m_axis_tdata;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]             m_axis_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]              m_axis_tuser;
  logic                                         m_axis_tvalid;
  logic                                         m_axis_tlast;
  logic                                         m_axis_tready;
  logic [IW-1:0]                                grant_idx;

  // The arbiter itself.
  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready,
    output grant_idx
  );

  // Sources plus downstream sink.
  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready,
    input  grant_idx
  );

endinterface

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// rtl/pkt_rr_arbiter_rr_pick.sv - combinational round-robin finder: first set request at or after start
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int p;
    logic [IW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    p     = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      cand = p[IW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// rtl/pkt_rr_arbiter.sv - packet-granular round-robin merge of C_NUM_PORTS streams
// Optional per-port packet counters when PKT_ARB_STATS_EN is defined.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS          = 4
) (
  input  logic clk,
  input  logic rst,
  pkt_rr_arbiter_if.slave bus
`ifdef PKT_ARB_STATS_EN
  ,
  input  logic                           stats_clear,
  output logic [C_NUM_PORTS*CNT_W-1:0]   pkt_cnt
`endif
);
  localparam int IW = idx_w(C_NUM_PORTS);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  arb_state_t    state, state_n;
  logic [IW-1:0] grant, grant_n;
  logic [IW-1:0] last_grant, last_grant_n;
  logic [IW-1:0] base, start_idx, win_idx;
  logic          win_found;
  logic          last_beat;

  // In FWD the search runs from grant+1, which leaves the current grantee last in line.
  assign base      = (state == IDLE) ? last_grant : grant;
  assign start_idx = (base == IW'(C_NUM_PORTS - 1)) ? '0 : base + 1'b1;

  rr_pick #(.N(C_NUM_PORTS), .IW(IW)) u_pick (
    .req   (bus.s_axis_tvalid),
    .start (start_idx),
    .found (win_found),
    .idx   (win_idx)
  );

  assign bus.m_axis_tdata = bus.s_axis_tdata[grant*DW +: DW];
  assign bus.m_axis_tkeep = bus.s_axis_tkeep[grant*KW +: KW];
  assign bus.m_axis_tuser = bus.s_axis_tuser[grant*UW +: UW];
  assign bus.grant_idx    = grant;

  assign last_beat = (state == FWD) && bus.s_axis_tvalid[grant]
                     && bus.m_axis_tready && bus.s_axis_tlast[grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(C_NUM_PORTS - 1);
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
    end
  end

  always_comb begin
    state_n           = state;
    grant_n           = grant;
    last_grant_n      = last_grant;
    bus.s_axis_tready = '0;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_n = win_idx;
          state_n = FWD;
        end
      end
      FWD: begin
        bus.s_axis_tready[grant] = bus.m_axis_tready;
        bus.m_axis_tvalid        = bus.s_axis_tvalid[grant];
        bus.m_axis_tlast         = bus.s_axis_tlast[grant];
        if (last_beat) begin
          last_grant_n = grant;
          if (win_found) grant_n = win_idx;
          else           state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PKT_ARB_STATS_EN
  logic [C_NUM_PORTS-1:0] pkt_done;
  assign pkt_done = bus.s_axis_tvalid & bus.s_axis_tready & bus.s_axis_tlast;

  always_ff @(posedge clk) begin
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      if (rst || stats_clear)
        pkt_cnt[i*CNT_W +: CNT_W] <= '0;
      else if (pkt_done[i])
        pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb/tb_pkt_rr_arbiter.sv - table-driven bench for pkt_rr_arbiter (stats checks when PKT_ARB_STATS_EN)
module tb_pkt_rr_arbiter;
  import pkt_arb_pkg::*;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_rr_arbiter_if #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_NUM_PORTS(N)) bus ();

`ifdef PKT_ARB_STATS_EN
  logic              stats_clear = 1'b0;
  logic [N*32-1:0]   pkt_cnt;
`endif

  pkt_rr_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_NUM_PORTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PKT_ARB_STATS_EN
    ,
    .stats_clear (stats_clear),
    .pkt_cnt     (pkt_cnt)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       rdy;
    logic       chk;
    logic       mv;
    logic       ml;
    logic [1:0] gi;
    logic [3:0] sr;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [DW-1:0] mk_data(input int p, input logic [7:0] tag);
    return {8'hA5, 8'(p), 8'h3C, tag};
  endfunction

  function automatic logic [UW-1:0] mk_user(input int p, input logic [7:0] tag);
    return {4'(p), tag[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                       input logic rdy, input logic [7:0] tag);
    rst                = r;
    bus.s_axis_tvalid  = vld;
    bus.s_axis_tlast   = lst;
    bus.m_axis_tready  = rdy;
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tdata[i*DW +: DW] = mk_data(i, tag);
      bus.s_axis_tkeep[i*4 +: 4]   = 4'(i + 1);
      bus.s_axis_tuser[i*UW +: UW] = mk_user(i, tag);
    end
  endtask

  initial begin
    // rst, vld, lst, rdy, chk, mv, ml, gi, sr
    // single source on port 2, 3-beat packets back to back
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000});
    for (int p = 0; p < 3; p++) begin
      vecs.push_back('{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100});
      vecs.push_back('{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100});
      vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100});
    end
    // all four ports, 2-beat packets: order 0,1,2,3,0
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000});
    for (int p = 0; p < 4; p++) begin
      vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'(p), 4'(1 << p)});
      vecs.push_back('{1'b0, 4'b1111, 4'(1 << p), 1'b1, 1'b1, 1'b1, 1'b1, 2'(p), 4'(1 << p)});
    end
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001});
    // port 1 mid-packet with tready 1,0,0,1 while port 3 waits
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b1010, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0000});
    vecs.push_back('{1'b0, 4'b1010, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010});
    vecs.push_back('{1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1000});
    // reset on beat 2 of a 4-beat packet, then port 0 wins with all valid
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001});
    // granted port bubbles mid-packet while others are valid: grant held
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000});
    vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{1'b0, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001});
    vecs.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001});
    vecs.push_back('{1'b0, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010});

    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b1111, 1'b1, 8'h11);
    #1;
    check("reset_m_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    check("reset_m_tlast",  32'(bus.m_axis_tlast),  32'd0);
    check("reset_s_tready", 32'(bus.s_axis_tready), 32'd0);
    check("reset_grant_idx", 32'(bus.grant_idx),    32'd0);
    check("reset_m_tdata",  32'(bus.m_axis_tdata),  32'(mk_data(0, 8'h11)));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].vld, vecs[i].lst, vecs[i].rdy, 8'(i));
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_m_tvalid", i), 32'(bus.m_axis_tvalid), 32'(vecs[i].mv));
        check($sformatf("v%0d_m_tlast", i),  32'(bus.m_axis_tlast),  32'(vecs[i].ml));
        check($sformatf("v%0d_grant_idx", i), 32'(bus.grant_idx),    32'(vecs[i].gi));
        check($sformatf("v%0d_s_tready", i), 32'(bus.s_axis_tready), 32'(vecs[i].sr));
        if (vecs[i].mv) begin
          check($sformatf("v%0d_m_tdata", i), 32'(bus.m_axis_tdata), 32'(mk_data(int'(vecs[i].gi), 8'(i))));
          check($sformatf("v%0d_m_tkeep", i), 32'(bus.m_axis_tkeep), 32'(int'(vecs[i].gi) + 1));
          check($sformatf("v%0d_m_tuser", i), 32'(bus.m_axis_tuser), 32'(mk_user(int'(vecs[i].gi), 8'(i))));
        end
      end
    end

`ifdef PKT_ARB_STATS_EN
    @(negedge clk);
    drive(1'b1, 4'b0000, 4'b0000, 1'b1, 8'h00);
    // 1-beat packets: ports 0,3,0,3 alternate, then port 0 alone three more times
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b0, (c < 5) ? 4'b1001 : 4'b0001, (c < 5) ? 4'b1001 : 4'b0001, 1'b1, 8'(c));
    end
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h00);
    #1;
    check("stats_port0_cnt", pkt_cnt[0 +: 32],  32'd5);
    check("stats_port1_cnt", pkt_cnt[32 +: 32], 32'd0);
    check("stats_port3_cnt", pkt_cnt[96 +: 32], 32'd2);
    @(negedge clk);
    drive(1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    drive(1'b0, 4'b0001, 4'b0001, 1'b1, 8'h00);
    #1;
    check("stats_clear_port0", pkt_cnt[0 +: 32],  32'd0);
    check("stats_clear_port3", pkt_cnt[96 +: 32], 32'd0);
    @(negedge clk);
    drive(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h00);
    #1;
    check("stats_after_clear_port0", pkt_cnt[0 +: 32], 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
# pkt_rr_arbiter

Packet-granular round-robin arbiter that merges `C_NUM_PORTS` ingress AXI-Stream sources into one stream feeding the pipeline's packet filter stage. A grant is held from a packet's first beat through its `tlast` beat, so packets are never interleaved. Arbitration re-runs on the `tlast` handshake with no bubble. The datapath is a combinational mux selected by a registered grant.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 256, data width per port
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width per port
- `C_NUM_PORTS`, 4, number of ingress sources (2..8)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `s_axis_tdata`  in  `C_NUM_PORTS*C_S_AXIS_DATA_WIDTH`  flattened, port i at slice i
- `s_axis_tkeep`  in  `C_NUM_PORTS*C_S_AXIS_DATA_WIDTH/8`  flattened keep
- `s_axis_tuser`  in  `C_NUM_PORTS*C_S_AXIS_TUSER_WIDTH`  flattened tuser
- `s_axis_tvalid`  in  `C_NUM_PORTS`  per-port valid
- `s_axis_tlast`  in  `C_NUM_PORTS`  per-port last
- `s_axis_tready`  out  `C_NUM_PORTS`  per-port ready
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tuser`  out  `C_S_AXIS_DATA_WIDTH`, `C_S_AXIS_DATA_WIDTH/8`, `C_S_AXIS_TUSER_WIDTH`  merged output
- `m_axis_tvalid`  out  1  output valid
- `m_axis_tlast`  out  1  output last
- `m_axis_tready`  in  1  downstream ready
- `grant_idx`  out  `$clog2(C_NUM_PORTS)`  currently granted port (debug)

## Operation
- States: `IDLE`, `FWD`. Registers: `state`, `grant`, `last_grant`.
- Round-robin search: starts at `last_grant+1` modulo `C_NUM_PORTS` and takes the first port with `s_axis_tvalid` high.
- `IDLE`:
  - All `s_axis_tready` are 0 and `m_axis_tvalid` is 0.
  - If any port is valid: `grant` <= winner, `state` <= `FWD`.
- `FWD`:
  - `m_axis_*` = slice `grant` of `s_axis_*`.
  - `s_axis_tready[grant]` = `m_axis_tready`; all other ready bits are 0.
- Last beat in `FWD` (`s_axis_tvalid[grant] & m_axis_tready & s_axis_tlast[grant]`):
  - `last_grant` <= `grant`.
  - Arbitration re-runs in the same cycle; the current grantee is eligible only last in the search order.
  - If a winner exists: stay in `FWD` with the new `grant`. Otherwise go to `IDLE`.
- A grant is never changed mid-packet, regardless of other ports' valids.
- While `m_axis_tready` = 0, the grant and state are held.
- A granted port may deassert `tvalid` between beats (bubbles). The grant is held until its `tlast` beat.
- Sources must keep `tvalid` and data stable until accepted (AXI-Stream rule). The arbiter does not check this.

## Timing
- Reset values:
  - `state`=`IDLE`, `grant`=0, `last_grant`=`C_NUM_PORTS-1` (port 0 wins first).
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `s_axis_tready`=0, `grant_idx`=0.
  - `m_axis_tdata/tkeep/tuser` are driven from slice 0.
- Latency from `IDLE`: a first `tvalid` in cycle N gives a grant at edge N+1; the first beat is presented on `m_axis` in cycle N+1.
- In `FWD`: zero-cycle combinational pass-through; throughput is one beat per cycle.
- Back-to-back packets: no idle cycle between packet k's `tlast` beat and packet k+1's first beat.
- Reset mid-packet: return to `IDLE` at the next edge. The truncated packet is not completed; the downstream filter resynchronises on its next first beat.
- Simultaneous `tlast` on the granted port and new valids elsewhere resolve through the same-cycle rule above.

## Configuration
- `PKT_ARB_STATS_EN` defined adds the following:
  - Port `stats_clear` (in, 1): synchronous clear of all counters.
  - Port `pkt_cnt` (out, `C_NUM_PORTS*32`): per-port 32-bit packet counters.
  - A counter increments on each accepted `tlast` beat of its port and wraps from 0xFFFFFFFF to 0.
  - Counters reset to 0 on `rst`. `stats_clear` takes priority over a same-cycle increment.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `pkt_arb_pkg`: state encoding (`IDLE`=0, `FWD`=1), port-index width function, counter width constant (32).
- Sub-module `rr_pick`: combinational round-robin finder.
  - Inputs: request vector and start index.
  - Outputs: `found` and winner index.
  - Used for both the `IDLE` search and the same-cycle `tlast` search.

## Test plan
- Single source: port 2 sends 3-beat packets back-to-back, `m_axis_tready`=1.
  - Expect `grant_idx`=2 throughout.
  - Expect a 1-cycle gap only before the first packet, then no gaps.
- All four ports valid with 2-beat packets. Expect output order 0,1,2,3,0 with no bubbles and no interleaving.
- Port 1 mid-packet with `tready` toggling 1,0,0,1 and port 3 valid.
  - Expect port 1's beats to be unchanged and in order.
  - Expect port 3 to start only in the cycle after port 1's `tlast` handshake.
- `rst` asserted on beat 2 of a 4-beat packet.
  - Expect `m_axis_tvalid`=0 and all `s_axis_tready`=0 next cycle.
  - After release, expect port 0 to win when all ports are valid.
- With `PKT_ARB_STATS_EN`:
  - 5 packets on port 0 and 2 on port 3: expect `pkt_cnt` slice 0 = 5 and slice 3 = 2.
  - Preload slice 0 to 0xFFFFFFFF and send one packet on port 0: expect it to wrap to 0.
  - `stats_clear` coincident with a `tlast` beat: expect 0.
